// File: rtl/str_ds_frame_ctrl_pkg.sv
// Shared types and defaults for the streaming down-sample chain controllers.
//   ds_ctrl_state_t : acquisition controller states (idle, settle, stream)
//   DS_FRAME_LEN    : default samples per output frame
//   DS_SETTLE       : default number of chain outputs discarded after a start
package str_ds_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_STREAM = 2'd2
  } ds_ctrl_state_t;

  localparam int DS_FRAME_LEN = 16000;
  localparam int DS_SETTLE    = 64;

endpackage

// File: rtl/str_ds_frame_ctrl.sv
// Acquisition controller sitting between the down-sample chain output and the
// DMA/packet sink. On start it enables the chain, throws away the filter
// settling transient, then passes the decimated stream through in fixed-length
// frames marked with tlast, either once or continuously until a stop request.
//
// Ports:
//   clk, rst                 : single clock, synchronous active-high reset
//   cfg_start / cfg_stop     : one-cycle control pulses
//   cfg_continuous           : repeat frames until stop (captured at start)
//   chain_en                 : enables ADC valid into the chain
//   s_axis_*                 : decimated stream from the final FIR
//   m_axis_*                 : framed stream to the sink
//   busy                     : controller is not idle
//   frame_done               : one-cycle pulse after each completed frame
//   frame_count              : frames completed since the last start (wraps)
module str_ds_frame_ctrl
  import str_ds_frame_ctrl_pkg::*;
#(
  parameter int DW        = 24,
  parameter int FRAME_LEN = DS_FRAME_LEN,
  parameter int SETTLE    = DS_SETTLE,
  parameter int FC_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_stop,
  input  logic            cfg_continuous,
  output logic            chain_en,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [DW-1:0]   m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic            busy,
  output logic            frame_done,
  output logic [FC_W-1:0] frame_count
);

  localparam int SAMP_W   = $clog2(FRAME_LEN);
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  localparam logic [SAMP_W-1:0]   SAMP_LAST   = SAMP_W'(FRAME_LEN - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  ds_ctrl_state_t      state;
  logic [SAMP_W-1:0]   samp_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                cont_q;
  logic                stop_pend;
  logic                stream_beat;
  logic                last_beat;
  logic                keep_streaming;

  // A streamed beat needs both the chain and the sink; s_axis_tready mirrors
  // the sink in STREAM, so this is also the chain-side handshake.
  assign stream_beat = (state == S_STREAM) && s_axis_tvalid && m_axis_tready;
  assign last_beat   = stream_beat && (samp_cnt == SAMP_LAST);

  // A stop arriving on the very cycle of the last beat still ends the run.
  assign keep_streaming = cont_q && !stop_pend && !cfg_stop;

  // Zero-latency pass-through while streaming; otherwise the chain output is
  // drained (ready held high) and nothing is presented to the sink.
  assign m_axis_tdata = s_axis_tdata;

  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state == S_STREAM) begin
      s_axis_tready = m_axis_tready;
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tlast  = (samp_cnt == SAMP_LAST);
    end
  end

  // Controller FSM with its counters and registered status outputs.
  // chain_en and busy are loaded alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      samp_cnt    <= '0;
      settle_cnt  <= '0;
      cont_q      <= 1'b0;
      stop_pend   <= 1'b0;
      chain_en    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state       <= S_SETTLE;
            chain_en    <= 1'b1;
            busy        <= 1'b1;
            settle_cnt  <= '0;
            samp_cnt    <= '0;
            frame_count <= '0;
            stop_pend   <= 1'b0;
            cont_q      <= cfg_continuous;
          end
        end

        S_SETTLE: begin
          if (cfg_stop) begin
            state    <= S_IDLE;
            chain_en <= 1'b0;
            busy     <= 1'b0;
          end else if (s_axis_tvalid) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
              state <= S_STREAM;
            end
          end
        end

        S_STREAM: begin
          if (cfg_stop) begin
            stop_pend <= 1'b1;
          end
          if (last_beat) begin
            samp_cnt    <= '0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
            if (!keep_streaming) begin
              state    <= S_IDLE;
              chain_en <= 1'b0;
              busy     <= 1'b0;
            end
          end else if (stream_beat) begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          chain_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_str_ds_frame_ctrl.sv
// Self-checking bench for str_ds_frame_ctrl with a short frame and settle time.
// A ramp source stands in for the chain (advancing only on accepted beats and
// producing data only while chain_en is high); a randomly stalling sink takes
// the framed output. A transaction-level model tracks run/settle/stream phase,
// frame boundaries and counters from the controller's rules.
module tb_str_ds_frame_ctrl;

  localparam int DW        = 24;
  localparam int FRAME_LEN = 8;
  localparam int SETTLE    = 4;
  localparam int FC_W      = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic            cfg_stop;
  logic            cfg_continuous;
  logic            chain_en;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            busy;
  logic            frame_done;
  logic [FC_W-1:0] frame_count;

  str_ds_frame_ctrl #(
    .DW(DW), .FRAME_LEN(FRAME_LEN), .SETTLE(SETTLE), .FC_W(FC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_continuous(cfg_continuous),
    .chain_en(chain_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Source/sink behaviour knobs (percent probabilities).
  int vld_pct = 100;
  int rdy_pct = 100;
  int ramp    = 0;

  // Reference model state.
  bit m_active    = 1'b0;
  int settle_seen = 0;
  int beats       = 0;
  bit m_cont      = 1'b0;
  bit m_stop      = 1'b0;
  int m_fc        = 0;
  bit done_exp    = 1'b0;
  bit chk_en      = 1'b0;
  int done_cnt    = 0;

  logic [DW-1:0] got_data[$];
  bit            got_last[$];

  // One clock cycle: compare against the model at the current (settled)
  // point, advance the model for the coming edge, then drive new inputs.
  task automatic cycle();
    bit s_hs;
    bit m_hs;
    bit done_next;
    logic [DW-1:0] exp_data;
    #1;
    s_hs = s_axis_tvalid && s_axis_tready;
    m_hs = m_axis_tvalid && m_axis_tready;
    if (chk_en) begin
      checks++;
      if (busy !== m_active) begin
        failures++; $display("[TB] FAIL busy: got %b expected %b", busy, m_active);
      end
      checks++;
      if (chain_en !== m_active) begin
        failures++; $display("[TB] FAIL chain_en: got %b expected %b", chain_en, m_active);
      end
      checks++;
      if (frame_done !== done_exp) begin
        failures++; $display("[TB] FAIL frame_done: got %b expected %b", frame_done, done_exp);
      end
      checks++;
      if (frame_count !== FC_W'(m_fc)) begin
        failures++; $display("[TB] FAIL frame_count: got %0d expected %0d", frame_count, m_fc);
      end
      if (m_active && settle_seen >= SETTLE) begin
        checks++;
        if (s_axis_tready !== m_axis_tready) begin
          failures++; $display("[TB] FAIL tready_mirror: got %b expected %b", s_axis_tready, m_axis_tready);
        end
        checks++;
        if (m_axis_tvalid !== s_axis_tvalid) begin
          failures++; $display("[TB] FAIL tvalid_pass: got %b expected %b", m_axis_tvalid, s_axis_tvalid);
        end
        checks++;
        if (m_axis_tlast !== ((beats % FRAME_LEN) == FRAME_LEN - 1)) begin
          failures++; $display("[TB] FAIL tlast: got %b at stream beat %0d", m_axis_tlast, beats);
        end
        if (m_hs) begin
          exp_data = DW'(SETTLE + beats);
          checks++;
          if (m_axis_tdata !== exp_data) begin
            failures++; $display("[TB] FAIL tdata: got %0d expected %0d", m_axis_tdata, exp_data);
          end
        end
      end else begin
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL not_streaming: got tvalid=%b tlast=%b s_tready=%b expected 0 0 1",
                   m_axis_tvalid, m_axis_tlast, s_axis_tready);
        end
      end
    end
    if (m_hs) begin
      got_data.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
    end

    done_next = 1'b0;
    if (rst) begin
      m_active = 1'b0; settle_seen = 0; beats = 0; m_fc = 0; m_stop = 1'b0;
    end else if (!m_active) begin
      if (cfg_start) begin
        m_active = 1'b1; settle_seen = 0; beats = 0; m_fc = 0; m_stop = 1'b0;
        m_cont = cfg_continuous;
      end
    end else if (settle_seen < SETTLE) begin
      if (cfg_stop) m_active = 1'b0;
      else if (s_hs) settle_seen++;
    end else begin
      if (cfg_stop) m_stop = 1'b1;
      if (m_hs) begin
        if ((beats % FRAME_LEN) == FRAME_LEN - 1) begin
          done_next = 1'b1;
          m_fc++;
          if (!m_cont || m_stop) m_active = 1'b0;
        end
        beats++;
      end
    end
    done_exp = done_next;

    @(posedge clk);
    @(negedge clk);
    if (s_hs) ramp++;
    if (frame_done) done_cnt++;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    s_axis_tvalid = chain_en && (int'($urandom_range(99)) < vld_pct);
    s_axis_tdata  = DW'(ramp);
    m_axis_tready = int'($urandom_range(99)) < rdy_pct;
  endtask

  task automatic start_run(input bit cont);
    ramp           = 0;
    s_axis_tdata   = '0;
    cfg_continuous = cont;
    cfg_start      = 1'b1;
    cycle();
  endtask

  task automatic finish_run(input int budget);
    for (int i = 0; i < budget && m_active; i++) cycle();
    checks++;
    if (m_active) begin
      failures++; $display("[TB] FAIL run_timeout: still active after %0d cycles", budget);
    end
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    chk_en = 1'b0;
    cycle();
    cycle();
    checks++;
    if (chain_en !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
        frame_done !== 1'b0 || busy !== 1'b0 || frame_count !== '0 || s_axis_tready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_values: got en=%b tv=%b tl=%b fd=%b busy=%b fc=%0d str=%b expected 0 0 0 0 0 0 1",
               chain_en, m_axis_tvalid, m_axis_tlast, frame_done, busy, frame_count, s_axis_tready);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    cycle();
  endtask

  task automatic test_single_shot();
    int d0;
    got_data.delete(); got_last.delete();
    d0 = done_cnt;
    start_run(1'b0);
    finish_run(200);
    checks++;
    if (got_data.size() != FRAME_LEN) begin
      failures++; $display("[TB] FAIL single_len: got %0d expected %0d", got_data.size(), FRAME_LEN);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== DW'(SETTLE + i) || got_last[i] != (i == FRAME_LEN - 1)) begin
        failures++;
        $display("[TB] FAIL single_beat%0d: got data=%0d last=%b expected %0d %b",
                 i, got_data[i], got_last[i], SETTLE + i, i == FRAME_LEN - 1);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || frame_count !== FC_W'(1) || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_end: got done=%0d fc=%0d busy=%b expected 1 1 0",
               done_cnt - d0, frame_count, busy);
    end
  endtask

  task automatic test_continuous();
    got_data.delete(); got_last.delete();
    start_run(1'b1);
    for (int i = 0; i < 300 && got_data.size() < 3 * FRAME_LEN; i++) begin
      if (got_data.size() == 10) cfg_start = 1'b1;
      cycle();
    end
    checks++;
    if (got_data.size() < 3 * FRAME_LEN) begin
      failures++; $display("[TB] FAIL cont_timeout: got %0d beats expected %0d", got_data.size(), 3 * FRAME_LEN);
    end
    cfg_stop = 1'b1;
    cycle();
    finish_run(200);
    checks++;
    if (got_data.size() != 4 * FRAME_LEN || frame_count !== FC_W'(4)) begin
      failures++;
      $display("[TB] FAIL cont_len: got %0d beats fc=%0d expected %0d 4", got_data.size(), frame_count, 4 * FRAME_LEN);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== DW'(SETTLE + i) || got_last[i] != ((i % FRAME_LEN) == FRAME_LEN - 1)) begin
        failures++;
        $display("[TB] FAIL cont_beat%0d: got data=%0d last=%b expected %0d", i, got_data[i], got_last[i], SETTLE + i);
      end
    end
  endtask

  task automatic test_stop_frame2();
    got_data.delete(); got_last.delete();
    start_run(1'b1);
    for (int i = 0; i < 300 && got_data.size() < FRAME_LEN + 6; i++) cycle();
    cfg_stop = 1'b1;
    cycle();
    finish_run(200);
    checks++;
    if (got_data.size() != 2 * FRAME_LEN || frame_count !== FC_W'(2) || chain_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_f2: got %0d beats fc=%0d en=%b expected %0d 2 0",
               got_data.size(), frame_count, chain_en, 2 * FRAME_LEN);
    end
    checks++;
    if (got_data.size() == 2 * FRAME_LEN && (!got_last[FRAME_LEN - 1] || !got_last[2 * FRAME_LEN - 1])) begin
      failures++; $display("[TB] FAIL stop_f2_tlast: got missing tlast expected at 7 and 15");
    end
  endtask

  task automatic test_stall();
    got_data.delete(); got_last.delete();
    vld_pct = 70;
    rdy_pct = 50;
    start_run(1'b1);
    for (int i = 0; i < 2000 && got_data.size() < 5 * FRAME_LEN; i++) cycle();
    cfg_stop = 1'b1;
    cycle();
    finish_run(1000);
    checks++;
    if (got_data.size() < 5 * FRAME_LEN || (got_data.size() % FRAME_LEN) != 0) begin
      failures++; $display("[TB] FAIL stall_len: got %0d beats expected a multiple of %0d >= %0d",
                           got_data.size(), FRAME_LEN, 5 * FRAME_LEN);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== DW'(SETTLE + i) || got_last[i] != ((i % FRAME_LEN) == FRAME_LEN - 1)) begin
        failures++;
        $display("[TB] FAIL stall_beat%0d: got data=%0d last=%b expected %0d", i, got_data[i], got_last[i], SETTLE + i);
      end
    end
    vld_pct = 100;
    rdy_pct = 100;
  endtask

  task automatic test_stop_in_settle();
    got_data.delete(); got_last.delete();
    start_run(1'b1);
    cycle();
    cfg_stop = 1'b1;
    cycle();
    checks++;
    if (busy !== 1'b0 || chain_en !== 1'b0 || got_data.size() != 0) begin
      failures++;
      $display("[TB] FAIL settle_stop: got busy=%b en=%b beats=%0d expected 0 0 0", busy, chain_en, got_data.size());
    end
    for (int i = 0; i < 3; i++) cycle();
    start_run(1'b0);
    finish_run(200);
    checks++;
    if (got_data.size() != FRAME_LEN) begin
      failures++; $display("[TB] FAIL settle_restart_len: got %0d expected %0d", got_data.size(), FRAME_LEN);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== DW'(SETTLE + i)) begin
        failures++; $display("[TB] FAIL settle_restart%0d: got %0d expected %0d", i, got_data[i], SETTLE + i);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    got_data.delete(); got_last.delete();
    start_run(1'b1);
    for (int i = 0; i < 300 && got_data.size() < FRAME_LEN + 3; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || frame_count !== '0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid: got tvalid=%b fc=%0d busy=%b expected 0 0 0", m_axis_tvalid, frame_count, busy);
    end
    got_data.delete(); got_last.delete();
    cycle();
    start_run(1'b0);
    finish_run(200);
    checks++;
    if (got_data.size() != FRAME_LEN || frame_count !== FC_W'(1)) begin
      failures++; $display("[TB] FAIL reset_restart: got %0d beats fc=%0d expected %0d 1", got_data.size(), frame_count, FRAME_LEN);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== DW'(SETTLE + i) || got_last[i] != (i == FRAME_LEN - 1)) begin
        failures++; $display("[TB] FAIL reset_restart%0d: got %0d expected %0d", i, got_data[i], SETTLE + i);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    cfg_start      = 1'b0;
    cfg_stop       = 1'b0;
    cfg_continuous = 1'b0;
    s_axis_tvalid  = 1'b0;
    s_axis_tdata   = '0;
    m_axis_tready  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_shot();
    test_continuous();
    test_stop_frame2();
    test_stall();
    test_stop_in_settle();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
